wb_dev_router: RTL and testbench
================================

// Module: wb_dev_router
// PURPOSE
//  Parametrised Wishbone slave-to-device router, successor of the fixed 10+1 channel adapter.
//  Decodes one Wishbone slave port onto NUM_DEV small IO-device windows plus one optional default (overflow) port.
//  Registers all device-side outputs and adds a bus-error path: unmapped access, and a watchdog timeout on silent devices.
//  Sits between the system Wishbone interconnect and the IO device cluster.
// PARAMETERS
//  TOTAL_ADDR_BITS   16   width of IO address space (byte address)
//  SINGLE_ADDR_BITS  8    width of each device window (byte address)
//  NUM_DEV           10   number of windowed devices, 1..2**(TOTAL_ADDR_BITS-SINGLE_ADDR_BITS)
//  HAS_DEFAULT       1    1: indices >= NUM_DEV route to dflt port; 0: they return wbs_err_o
//  TIMEOUT           255  BUSY cycles without device ack before error, >= 1
// PORTS
//  clk          in   1                      system clock, rising edge
//  rst          in   1                      asynchronous reset, active-high
//  wbs_cyc_i    in   1                      Wishbone cycle valid
//  wbs_stb_i    in   1                      Wishbone strobe
//  wbs_addr_i   in   TOTAL_ADDR_BITS-2      word address [TOTAL_ADDR_BITS-1:2]
//  wbs_sel_i    in   4                      byte select
//  wbs_we_i     in   1                      write enable
//  wbs_data_i   in   32                     write data
//  wbs_data_o   out  32                     read data
//  wbs_ack_o    out  1                      transfer acknowledge, 1-cycle pulse
//  wbs_err_o    out  1                      transfer error, 1-cycle pulse
//  dev_cs_o     out  NUM_DEV                one-hot device chip select
//  dev_addr_o   out  SINGLE_ADDR_BITS-2     shared in-window word address
//  dev_sel_o    out  4                      shared byte select
//  dev_we_o     out  1                      shared write enable
//  dev_data_o   out  32                     shared write data
//  dev_data_i   in   32*NUM_DEV             read data, device k at [32k+31:32k]
//  dev_ack_i    in   NUM_DEV                per-device acknowledge
//  dflt_cs_o    out  1                      default-port chip select
//  dflt_addr_o  out  TOTAL_ADDR_BITS-2      full word address to default port
//  dflt_data_i  in   32                     default-port read data
//  dflt_ack_i   in   1                      default-port acknowledge
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timeout counter 0. rst mid-transfer aborts immediately; no ack/err is issued.
//  Decode: idx = wbs_addr_i[TOTAL_ADDR_BITS-1:SINGLE_ADDR_BITS].
//    idx < NUM_DEV -> device idx.
//    Otherwise -> default port if HAS_DEFAULT=1, else unmapped.
//  FSM IDLE: on cyc&stb, latch addr/sel/we/data into the dev_*/dflt_* output regs.
//    Mapped: assert exactly one cs next edge -> BUSY.
//    Unmapped: no cs; wbs_err_o=1 next edge -> DONE.
//  FSM BUSY: counter increments each cycle.
//    Selected ack=1: wbs_data_o<=selected read data (captured for reads and writes), wbs_ack_o<=1, cs<=0 -> DONE.
//    Else counter==TIMEOUT: wbs_err_o<=1, cs<=0 -> DONE. Ack in the same cycle wins over timeout.
//    cyc=0 (master abort): cs<=0, no ack/err -> IDLE.
//  FSM DONE: ack/err cleared, counter cleared -> IDLE unconditionally.
//    The one-cycle gap prevents retriggering on a stale strobe.
//  Acks from non-selected devices are ignored in every state; dev_*_o hold their values while cs=0.
//  Latency: stb seen at edge 0, cs high after edge 0; ack_i seen at edge n -> wbs_ack_o high for one cycle after edge n.
//  Minimum turnaround is 2 cycles; back-to-back transfers are spaced >= 3 cycles.
//  wbs_data_o holds its last captured value until the next ack.
// TESTING
//  1. Read dev 3 (addr 0x0344), dev ack 2 cycles after cs, data 0xA5A5_0003 -> dev_cs_o=0x008, dev_addr_o=0x11, wbs_ack_o pulse, wbs_data_o=0xA5A5_0003.
//  2. Write 0xDEADBEEF sel=0x6 to 0x0910 -> dev_cs_o=0x200, we=1, sel=0x6, data seen; single ack; cs drops next cycle.
//  3. Addr 0x2000, HAS_DEFAULT=1 -> dflt_cs_o=1, dflt_addr_o=0x0800, ack from dflt; with HAS_DEFAULT=0 -> err 1 cycle after stb, no cs.
//  4. Dev 5 never acks, TIMEOUT=4 -> wbs_err_o pulses after 4 BUSY cycles, cs low; ack arriving in the timeout cycle -> ack, no err.
//  5. Spurious dev_ack_i[7] during dev 2 transfer -> ignored; cyc dropped mid-BUSY -> cs low, no ack/err, next request served normally.
//  6. rst asserted in BUSY -> all outputs 0 asynchronously; first request after release completes normally.

Source files
------------

// File: rtl/wb_dev_router.sv
// -----------------------------------------------------------------------------
// wb_dev_router
//
// Routes one Wishbone slave port onto NUM_DEV equally sized IO-device windows
// plus an optional default (overflow) port. The device-side outputs are all
// registered. A transfer ends with a bus error when the address decodes to
// nothing, or when the selected device stays silent for TIMEOUT busy cycles.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   wbs_*           Wishbone slave side (word address [TOTAL_ADDR_BITS-1:2])
//   dev_cs_o        one-hot chip select, one bit per device window
//   dev_addr_o      in-window word address, shared by all devices
//   dev_sel_o       byte select, shared
//   dev_we_o        write enable, shared
//   dev_data_o      write data, shared
//   dev_data_i      read data, device k at [32k+31:32k]
//   dev_ack_i       per-device acknowledge
//   dflt_cs_o       default-port chip select
//   dflt_addr_o     full word address for the default port
//   dflt_data_i     default-port read data
//   dflt_ack_i      default-port acknowledge
// -----------------------------------------------------------------------------
module wb_dev_router #(
    parameter int TOTAL_ADDR_BITS  = 16,
    parameter int SINGLE_ADDR_BITS = 8,
    parameter int NUM_DEV          = 10,
    parameter int HAS_DEFAULT      = 1,
    parameter int TIMEOUT          = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic [TOTAL_ADDR_BITS-3:0]   wbs_addr_i,
    input  logic [3:0]                   wbs_sel_i,
    input  logic                         wbs_we_i,
    input  logic [31:0]                  wbs_data_i,
    output logic [31:0]                  wbs_data_o,
    output logic                         wbs_ack_o,
    output logic                         wbs_err_o,
    output logic [NUM_DEV-1:0]           dev_cs_o,
    output logic [SINGLE_ADDR_BITS-3:0]  dev_addr_o,
    output logic [3:0]                   dev_sel_o,
    output logic                         dev_we_o,
    output logic [31:0]                  dev_data_o,
    input  logic [32*NUM_DEV-1:0]        dev_data_i,
    input  logic [NUM_DEV-1:0]           dev_ack_i,
    output logic                         dflt_cs_o,
    output logic [TOTAL_ADDR_BITS-3:0]   dflt_addr_o,
    input  logic [31:0]                  dflt_data_i,
    input  logic                         dflt_ack_i
);

    localparam int AW  = TOTAL_ADDR_BITS - 2;           // word address width
    localparam int DAW = SINGLE_ADDR_BITS - 2;          // in-window word address width
    localparam int IW  = TOTAL_ADDR_BITS - SINGLE_ADDR_BITS;  // window index width
    localparam int TW  = $clog2(TIMEOUT + 1);           // watchdog counter width
    localparam bit HAS_DFLT = (HAS_DEFAULT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [NUM_DEV-1:0]  cs_reg, cs_next;
    logic                dflt_cs_reg, dflt_cs_next;
    logic                ack_reg, ack_next;
    logic                err_reg, err_next;
    logic [31:0]         rdata_reg, rdata_next;
    logic [TW-1:0]       cnt_reg, cnt_next;
    logic [DAW-1:0]      dev_addr_reg;
    logic [AW-1:0]       dflt_addr_reg;
    logic [3:0]          sel_reg;
    logic                we_reg;
    logic [31:0]         wdata_reg;
    logic                latch_req;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [IW-1:0]       idx;
    logic                req;
    logic                idx_in_range;
    logic [NUM_DEV-1:0]  dev_hit;

    assign idx          = wbs_addr_i[AW-1:DAW];
    assign req          = wbs_cyc_i & wbs_stb_i;
    // One extra bit so NUM_DEV == 2**IW still compares correctly.
    assign idx_in_range = ({1'b0, idx} < (IW+1)'(NUM_DEV));

    generate
        for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_hit
            assign dev_hit[gi] = (idx == IW'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Selected-target ack and read data. cs is one-hot (or all zero), so
    // masking each device with its cs bit and OR-ing gives a clean mux.
    // ------------------------------------------------------------------
    logic [31:0] dev_masked [NUM_DEV];
    logic [31:0] sel_data;
    logic        sel_ack;
    logic        timeout_hit;

    generate
        for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_mask
            assign dev_masked[gi] = dev_data_i[32*gi +: 32] & {32{cs_reg[gi]}};
        end
    endgenerate

    always_comb begin
        sel_data = dflt_data_i & {32{dflt_cs_reg}};
        for (int i = 0; i < NUM_DEV; i++) begin
            sel_data = sel_data | dev_masked[i];
        end
    end

    // Acks from devices that are not selected are masked off here.
    assign sel_ack     = (|(dev_ack_i & cs_reg)) | (dflt_ack_i & dflt_cs_reg);
    // The counter reaches TIMEOUT on this busy cycle.
    assign timeout_hit = (cnt_reg == TW'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cs_reg        <= '0;
            dflt_cs_reg   <= 1'b0;
            ack_reg       <= 1'b0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
            cnt_reg       <= '0;
            dev_addr_reg  <= '0;
            dflt_addr_reg <= '0;
            sel_reg       <= '0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            cs_reg      <= cs_next;
            dflt_cs_reg <= dflt_cs_next;
            ack_reg     <= ack_next;
            err_reg     <= err_next;
            rdata_reg   <= rdata_next;
            cnt_reg     <= cnt_next;
            if (latch_req) begin
                dev_addr_reg  <= wbs_addr_i[DAW-1:0];
                dflt_addr_reg <= wbs_addr_i;
                sel_reg       <= wbs_sel_i;
                we_reg        <= wbs_we_i;
                wdata_reg     <= wbs_data_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next = (idx_in_range || HAS_DFLT) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (sel_ack || timeout_hit) begin
                    state_next = DONE;
                end else if (!wbs_cyc_i) begin
                    state_next = IDLE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        cs_next      = cs_reg;
        dflt_cs_next = dflt_cs_reg;
        ack_next     = 1'b0;
        err_next     = 1'b0;
        rdata_next   = rdata_reg;
        cnt_next     = cnt_reg;
        latch_req    = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (req) begin
                    latch_req = 1'b1;
                    if (idx_in_range) begin
                        cs_next = dev_hit;
                    end else if (HAS_DFLT) begin
                        dflt_cs_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            BUSY: begin
                cnt_next = cnt_reg + 1'b1;
                // Ack wins over the watchdog when both land on the same cycle.
                if (sel_ack) begin
                    rdata_next   = sel_data;
                    ack_next     = 1'b1;
                    cs_next      = '0;
                    dflt_cs_next = 1'b0;
                end else if (timeout_hit) begin
                    err_next     = 1'b1;
                    cs_next      = '0;
                    dflt_cs_next = 1'b0;
                end else if (!wbs_cyc_i) begin
                    // Master abandoned the cycle: release the device silently.
                    cs_next      = '0;
                    dflt_cs_next = 1'b0;
                end
            end
            DONE: begin
                // One dead cycle so a strobe still high from the finished
                // transfer is not taken as a new request.
                cnt_next     = '0;
                cs_next      = '0;
                dflt_cs_next = 1'b0;
            end
            default: begin
                cs_next      = '0;
                dflt_cs_next = 1'b0;
            end
        endcase
    end

    assign wbs_data_o  = rdata_reg;
    assign wbs_ack_o   = ack_reg;
    assign wbs_err_o   = err_reg;
    assign dev_cs_o    = cs_reg;
    assign dev_addr_o  = dev_addr_reg;
    assign dev_sel_o   = sel_reg;
    assign dev_we_o    = we_reg;
    assign dev_data_o  = wdata_reg;
    assign dflt_cs_o   = dflt_cs_reg;
    assign dflt_addr_o = dflt_addr_reg;

endmodule

// File: tb/tb_wb_dev_router.sv
// -----------------------------------------------------------------------------
// tb_wb_dev_router
//
// Self-checking bench for wb_dev_router. Main instance: 10 devices, default
// port enabled, TIMEOUT=4. A second instance without the default port shares
// the address/data inputs but has its own cyc/stb, used for the unmapped case.
// The expected outcome of every transfer comes from a transfer-level model:
// target = byte address / 256, completion edge = ack latency or TIMEOUT.
// -----------------------------------------------------------------------------
module tb_wb_dev_router;

    localparam int NDEV = 10;
    localparam int TO   = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cyc = 1'b0, stb = 1'b0, cyc_b = 1'b0, stb_b = 1'b0;
    logic [13:0]  addr = '0;
    logic [3:0]   sel = '0;
    logic         we = 1'b0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata, rdata_b;
    logic         ack, err, ack_b, err_b;
    logic [NDEV-1:0] dev_cs, dev_cs_b;
    logic [5:0]   dev_addr, dev_addr_b;
    logic [3:0]   dev_sel, dev_sel_b;
    logic         dev_we, dev_we_b;
    logic [31:0]  dev_wdata, dev_wdata_b;
    logic [32*NDEV-1:0] dev_data;
    logic [NDEV-1:0] dev_ack = '0;
    logic         dflt_cs, dflt_cs_b;
    logic [13:0]  dflt_addr, dflt_addr_b;
    logic [31:0]  dflt_data = '0;
    logic         dflt_ack = 1'b0;

    logic [31:0]  dev_mem [NDEV];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        dev_data = '0;
        for (int k = 0; k < NDEV; k++) dev_data[32*k +: 32] = dev_mem[k];
    end

    wb_dev_router #(
        .TOTAL_ADDR_BITS(16), .SINGLE_ADDR_BITS(8), .NUM_DEV(NDEV),
        .HAS_DEFAULT(1), .TIMEOUT(TO)
    ) u_dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_addr_i(addr), .wbs_sel_i(sel),
        .wbs_we_i(we), .wbs_data_i(wdata), .wbs_data_o(rdata),
        .wbs_ack_o(ack), .wbs_err_o(err),
        .dev_cs_o(dev_cs), .dev_addr_o(dev_addr), .dev_sel_o(dev_sel),
        .dev_we_o(dev_we), .dev_data_o(dev_wdata),
        .dev_data_i(dev_data), .dev_ack_i(dev_ack),
        .dflt_cs_o(dflt_cs), .dflt_addr_o(dflt_addr),
        .dflt_data_i(dflt_data), .dflt_ack_i(dflt_ack)
    );

    wb_dev_router #(
        .TOTAL_ADDR_BITS(16), .SINGLE_ADDR_BITS(8), .NUM_DEV(NDEV),
        .HAS_DEFAULT(0), .TIMEOUT(TO)
    ) u_nodflt (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(cyc_b), .wbs_stb_i(stb_b), .wbs_addr_i(addr), .wbs_sel_i(sel),
        .wbs_we_i(we), .wbs_data_i(wdata), .wbs_data_o(rdata_b),
        .wbs_ack_o(ack_b), .wbs_err_o(err_b),
        .dev_cs_o(dev_cs_b), .dev_addr_o(dev_addr_b), .dev_sel_o(dev_sel_b),
        .dev_we_o(dev_we_b), .dev_data_o(dev_wdata_b),
        .dev_data_i(dev_data), .dev_ack_i(dev_ack),
        .dflt_cs_o(dflt_cs_b), .dflt_addr_o(dflt_addr_b),
        .dflt_data_i(dflt_data), .dflt_ack_i(dflt_ack)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_data();
        for (int k = 0; k < NDEV; k++) dev_mem[k] = $urandom;
        dflt_data = $urandom;
    endtask

    // One complete transfer on the main instance.
    // ack_lat: edge (counted from cs assertion) at which the target acks;
    //          values above TO mean the target never acks in time.
    task automatic run_xfer(input logic [15:0] baddr, input bit w, input logic [3:0] s,
                            input logic [31:0] d, input int ack_lat, input bit spur);
        int          tgt;
        bit          is_dflt;
        logic [31:0] exp_rdata;
        logic [NDEV-1:0] exp_cs;
        bit          exp_ack;
        int          exp_edge;
        int          got_edge;
        int          j;

        tgt       = int'(baddr) / 256;
        is_dflt   = (tgt >= NDEV);
        exp_rdata = is_dflt ? dflt_data : dev_mem[tgt];
        exp_cs    = '0;
        if (!is_dflt) exp_cs[tgt] = 1'b1;
        exp_ack   = (ack_lat >= 1) && (ack_lat <= TO);
        exp_edge  = exp_ack ? ack_lat : TO;

        addr = baddr[15:2]; sel = s; we = w; wdata = d;
        cyc = 1'b1; stb = 1'b1;
        tick();
        check_eq("cs",        64'(dev_cs),    64'(exp_cs));
        check_eq("dflt_cs",   64'(dflt_cs),   64'(is_dflt));
        check_eq("dev_addr",  64'(dev_addr),  64'(baddr[7:2]));
        check_eq("dflt_addr", 64'(dflt_addr), 64'(baddr[15:2]));
        check_eq("dev_sel",   64'(dev_sel),   64'(s));
        check_eq("dev_we",    64'(dev_we),    64'(w));
        check_eq("dev_wdata", 64'(dev_wdata), 64'(d));
        check_eq("early_resp", 64'({ack, err}), 64'(0));

        got_edge = -1;
        for (int e = 1; e <= TO + 1; e++) begin
            dev_ack  = '0;
            dflt_ack = 1'b0;
            if (ack_lat == e) begin
                if (is_dflt) dflt_ack = 1'b1;
                else         dev_ack[tgt] = 1'b1;
            end
            if (spur) begin
                j = $urandom_range(0, NDEV - 1);
                if (is_dflt || j != tgt) dev_ack[j] = 1'b1;
            end
            tick();
            dev_ack  = '0;
            dflt_ack = 1'b0;
            if (ack || err) begin
                got_edge = e;
                break;
            end
            check_eq("cs_hold", 64'({dflt_cs, dev_cs}), 64'({is_dflt, exp_cs}));
        end

        check_eq("resp_edge", 64'(got_edge), 64'(exp_edge));
        check_eq("ack", 64'(ack), 64'(exp_ack));
        check_eq("err", 64'(err), 64'(!exp_ack));
        if (exp_ack) check_eq("rdata", 64'(rdata), 64'(exp_rdata));
        check_eq("cs_drop", 64'({dflt_cs, dev_cs}), 64'(0));
        $display("xfer addr=%h we=%0d sel=%h lat=%0d spur=%0d -> ack=%0d err=%0d edge=%0d rdata=%h",
                 baddr, w, s, ack_lat, spur, ack, err, got_edge, rdata);

        cyc = 1'b0; stb = 1'b0;
        tick();
        check_eq("pulse_end", 64'({ack, err}), 64'(0));
        if (exp_ack) check_eq("rdata_hold", 64'(rdata), 64'(exp_rdata));
        tick();
    endtask

    initial begin
        logic [15:0] ba;
        int          ix;

        randomize_data();
        #1;
        check_eq("rst_outputs", 64'({ack, err, dflt_cs, dev_cs, dev_we}), 64'(0));
        check_eq("rst_data", 64'({rdata, dev_wdata}), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        // Directed transfers
        dev_mem[3] = 32'hA5A5_0003;
        run_xfer(16'h0344, 1'b0, 4'hF, 32'h0, 2, 1'b0);
        run_xfer(16'h0910, 1'b1, 4'h6, 32'hDEAD_BEEF, 1, 1'b0);
        run_xfer(16'h2000, 1'b0, 4'hF, 32'h0, 3, 1'b0);
        run_xfer(16'h0500, 1'b0, 4'hF, 32'h0, TO + 1, 1'b0);  // watchdog
        run_xfer(16'h0504, 1'b0, 4'hF, 32'h0, TO, 1'b0);      // ack on the timeout cycle
        run_xfer(16'h0208, 1'b0, 4'hF, 32'h0, 3, 1'b1);       // spurious acks

        // Unmapped access on the instance without a default port
        addr = 14'h0800; cyc_b = 1'b1; stb_b = 1'b1;
        tick();
        check_eq("nodflt_err",  64'(err_b), 64'(1));
        check_eq("nodflt_cs",   64'({dflt_cs_b, dev_cs_b}), 64'(0));
        check_eq("nodflt_ack",  64'(ack_b), 64'(0));
        $display("xfer nodflt addr=2000 -> err=%0d ack=%0d", err_b, ack_b);
        cyc_b = 1'b0; stb_b = 1'b0;
        tick();
        check_eq("nodflt_err_end", 64'(err_b), 64'(0));
        tick();

        // Master abort mid-BUSY
        addr = 14'h0080; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        tick();
        check_eq("abort_cs_on", 64'(dev_cs), 64'(10'h004));
        tick();
        cyc = 1'b0; stb = 1'b0;
        tick();
        check_eq("abort_cs_off", 64'({dflt_cs, dev_cs}), 64'(0));
        check_eq("abort_resp", 64'({ack, err}), 64'(0));
        for (int k = 0; k < TO + 1; k++) begin
            dev_ack[2] = 1'b1;
            tick();
            dev_ack = '0;
            check_eq("abort_quiet", 64'({ack, err, dev_cs}), 64'(0));
        end
        $display("xfer abort addr=0200 -> cs=%h ack=%0d err=%0d", dev_cs, ack, err);
        randomize_data();
        run_xfer(16'h0240, 1'b0, 4'hF, 32'h0, 2, 1'b0);

        // Asynchronous reset in BUSY
        addr = 14'h0040; cyc = 1'b1; stb = 1'b1; we = 1'b1; wdata = 32'h1234_5678;
        tick();
        check_eq("prerst_cs", 64'(dev_cs), 64'(10'h002));
        #3 rst = 1'b1;
        #1;
        check_eq("async_rst_ctl", 64'({ack, err, dflt_cs, dev_cs, dev_we}), 64'(0));
        check_eq("async_rst_data", 64'({rdata, dev_wdata}), 64'(0));
        check_eq("async_rst_addr", 64'({dev_addr, dflt_addr, dev_sel}), 64'(0));
        $display("xfer reset-in-busy -> cs=%h rdata=%h", dev_cs, rdata);
        cyc = 1'b0; stb = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        run_xfer(16'h0104, 1'b0, 4'hF, 32'h0, 1, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 24; t++) begin
            randomize_data();
            ix = ($urandom_range(0, 3) == 0) ? $urandom_range(NDEV, 255) : $urandom_range(0, NDEV - 1);
            ba = {ix[7:0], 8'($urandom)};
            run_xfer(ba, 1'($urandom), 4'($urandom), $urandom,
                     $urandom_range(1, TO + 1), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
